serial_subtractor: RTL and testbench

//   Bit-serial unsigned/two's-complement subtractor: computes diff = a - b one bit
//   per clock, LSB first, using a single full-subtractor cell and a borrow flop.

---
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b computed LSB first, one full-subtractor
// cell plus a borrow flop, with valid/ready handshakes on operands and result.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  diff_sh;
    logic [CW-1:0] count;
    logic          br;
    logic          a_msb;
    logic          b_msb;
    logic          x;
    logic          y;
    logic          d;
    logic          br_n;
    logic          last;

    // Full-subtractor cell on the current LSB pair
    always_comb begin
        x          = a_sr[0];
        y          = b_sr[0];
        d          = x ^ y ^ br;
        br_n       = (~x & y) | (~(x ^ y) & br);
        last       = (count == CW'(W - 1));
        diff_sh    = diff >> 1;
        diff_sh[W-1] = d;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            count  <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        a_msb <= a[W-1];
                        b_msb <= b[W-1];
                        br    <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    diff  <= diff_sh;
                    br    <= br_n;
                    count <= count + CW'(1);
                    // d lands in diff[W-1] on this edge, so it is the result sign
                    if (last) begin
                        borrow <= br_n;
                        ovf    <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at W=8 and W=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow1, ovf1;
    logic [0:0] a1, b1, diff1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrow(borrow8), .ovf(ovf8)
    );

    serial_subtractor #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1), .ovf(ovf1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec8_t;

    typedef struct {
        logic [0:0] a;
        logic [0:0] b;
        logic [0:0] diff;
        logic       borrow;
        logic       ovf;
    } vec1_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: integer arithmetic on sign-extended operands
    task automatic model8(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic br, output logic ov);
        int sa, sb, s;
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        s  = sa - sb;
        d  = 8'((int'(a) - int'(b)) & 255);
        br = (a < b);
        ov = (s > 127) || (s < -128);
    endtask

    // Entry and exit at #1 after a rising edge
    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input logic eo);
        int lat;
        check({name, ".in_ready"}, 32'(in_ready8), 32'd1);
        a8 = a; b8 = b; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (out_valid8) begin lat = k; break; end
        end
        check({name, ".latency"}, 32'(lat), 32'd8);
        check({name, ".diff"}, 32'(diff8), 32'(ed));
        check({name, ".borrow"}, 32'(borrow8), 32'(eb));
        check({name, ".ovf"}, 32'(ovf8), 32'(eo));
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check({name, ".release"}, {30'd0, in_ready8, out_valid8}, 32'b10);
    endtask

    task automatic op1(input string name, input vec1_t v);
        int lat;
        a1 = v.a; b1 = v.b; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (out_valid1) begin lat = k; break; end
        end
        check({name, ".latency"}, 32'(lat), 32'd1);
        check({name, ".result"}, {29'd0, diff1, borrow1, ovf1}, {29'd0, v.diff, v.borrow, v.ovf});
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check({name, ".release"}, {30'd0, in_ready1, out_valid1}, 32'b10);
    endtask

    vec8_t      tab8[8];
    vec1_t      tab1[4];
    logic [7:0] qa[$], qb[$];
    logic [7:0] md;
    logic       mb, mo;
    int         sent, done, seen;

    initial begin
        tab8[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        tab8[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        tab8[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tab8[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tab8[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        tab8[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tab8[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tab8[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tab1[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab1[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset8.ctrl", {30'd0, in_ready8, out_valid8}, 32'b10);
        check("reset8.out", {22'd0, diff8, borrow8, ovf8}, 32'd0);
        check("reset1.out", {28'd0, in_ready1, out_valid1, diff1, borrow1}, 32'b1000);

        for (int i = 0; i < 8; i++)
            op8($sformatf("vec8[%0d]", i), tab8[i].a, tab8[i].b,
                tab8[i].diff, tab8[i].borrow, tab8[i].ovf);
        for (int i = 0; i < 4; i++)
            op1($sformatf("vec1[%0d]", i), tab1[i]);

        // Reset three cycles into RUN; diff already holds shifted-in bits
        a8 = 8'h55; b8 = 8'h00; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst.ctrl", {30'd0, in_ready8, out_valid8}, 32'b10);
        check("midrun_rst.out", {22'd0, diff8, borrow8, ovf8}, 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        check("midrun_rst.no_pulse", 32'(seen), 32'd0);
        op8("after_rst", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        // Backpressure with stray in_valid pulses during RUN and DONE
        a8 = 8'h3C; b8 = 8'h1E; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h01; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        seen = 0;
        for (int k = 0; k < 12 && !out_valid8; k++) begin
            @(posedge clk); #1;
        end
        check("bp.out_valid", 32'(out_valid8), 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid8 = k[0];
            @(posedge clk); #1;
            check($sformatf("bp.hold[%0d]", k),
                  {20'd0, in_ready8, out_valid8, diff8, borrow8, ovf8},
                  {20'd0, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0});
        end
        a8 = 8'h10; b8 = 8'h01; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("bp.no_overlap", {30'd0, in_ready8, out_valid8}, 32'b10);
        in_valid8 = 1'b0;

        // Back-to-back: in_valid held high, random out_ready
        sent = 0; done = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'b1;
        for (int cyc = 0; cyc < 600 && done < 16; cyc++) begin
            out_ready8 = 1'($urandom_range(0, 1));
            if (out_valid8 && out_ready8 && qa.size() > 0) begin
                model8(qa[0], qb[0], md, mb, mo);
                check($sformatf("b2b[%0d] %0h-%0h", done, qa[0], qb[0]),
                      {22'd0, diff8, borrow8, ovf8}, {22'd0, md, mb, mo});
                void'(qa.pop_front());
                void'(qb.pop_front());
                done++;
            end
            if (in_valid8 && in_ready8) begin
                qa.push_back(a8);
                qb.push_back(b8);
                sent++;
            end
            @(posedge clk); #1;
            if (sent >= 16) in_valid8 = 1'b0;
            else if (qa.size() > 0 && in_valid8 && !in_ready8) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        check("b2b.count", 32'(done), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
